// File: rtl/triple_byte_packer_pkg.sv
// Shared types for the triple byte packer: FSM state encoding and slot count.
package triple_byte_packer_pkg;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FULL  = 2'd3
  } state_t;

  localparam int unsigned SLOT_COUNT = 3;

endpackage

// File: rtl/triple_rotate_regs.sv
// Three WIDTH-bit slot registers with per-slot loads and a concurrent a<-b<-c<-a rotate.
module triple_rotate_regs #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             load_c,
  input  logic             rot_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else if (rot_en) begin
      // All three take pre-edge values, so the rotation never cascades.
      a <= b;
      b <= c;
      c <= a;
    end else begin
      if (load_a) a <= d;
      if (load_b) b <= d;
      if (load_c) c <= d;
    end
  end

endmodule

// File: rtl/triple_byte_packer.sv
// Packs three consecutive upstream words into slots a/b/c and hands the triple downstream.
module triple_byte_packer
  import triple_byte_packer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             rot_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [1:0]       fill_cnt,
  output logic [1:0]       rot_cnt
);

  state_t state;
  logic   in_xfer;
  logic   do_rot;

  assign out_valid = (state == FULL);
  assign fill_cnt  = state;
  // In FULL a word can only enter when the held triple leaves in the same cycle.
  assign in_ready  = (state != FULL) | out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign do_rot    = (state == FULL) & rot_en & ~out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL0;
      rot_cnt <= '0;
    end else begin
      unique case (state)
        FILL0: if (in_xfer) state <= FILL1;
        FILL1: if (in_xfer) state <= FILL2;
        FILL2: begin
          if (in_xfer) begin
            state   <= FULL;
            rot_cnt <= '0;
          end
        end
        FULL: begin
          if (out_ready) begin
            state <= in_valid ? FILL1 : FILL0;
          end else if (rot_en) begin
            rot_cnt <= (rot_cnt == 2'(SLOT_COUNT - 1)) ? 2'd0 : rot_cnt + 2'd1;
          end
        end
        default: state <= FILL0;
      endcase
    end
  end

  triple_rotate_regs #(
    .WIDTH(WIDTH)
  ) u_regs (
    .clk   (clk),
    .rst   (rst),
    .load_a(in_xfer & ((state == FILL0) | (state == FULL))),
    .load_b(in_xfer & (state == FILL1)),
    .load_c(in_xfer & (state == FILL2)),
    .rot_en(do_rot),
    .d     (in_data),
    .a     (out_a),
    .b     (out_b),
    .c     (out_c)
  );

endmodule

// File: tb/tb_triple_byte_packer.sv
// Scoreboard bench for triple_byte_packer: directed plan plus randomized traffic.
module tb_triple_byte_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       rot_en = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_a, out_b, out_c;
  logic [1:0] fill_cnt, rot_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: pending words, held triple and number of rotations applied.
  logic [7:0]  words[$];
  logic [7:0]  t[3];
  bit          held = 1'b0;
  int          mr = 0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;

  triple_byte_packer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rot_en(rot_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .fill_cnt(fill_cnt), .rot_cnt(rot_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // After r left-rotations slot i holds the word received in position (i+r) mod 3.
  function automatic logic [23:0] view();
    return {t[mr % 3], t[(mr + 1) % 3], t[(mr + 2) % 3]};
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d, input logic re,
                            input logic ordy, input logic r);
    bit ir;
    if (r) begin
      words.delete();
      held = 1'b0;
      mr = 0;
      return;
    end
    ir = !held || ordy;
    if (held) begin
      if (ordy) held = 1'b0;
      else if (re) mr = (mr + 1) % 3;
    end
    if (v && ir) begin
      words.push_back(d);
      if (words.size() == 3) begin
        for (int i = 0; i < 3; i++) t[i] = words[i];
        words.delete();
        held = 1'b1;
        mr = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, then advance the model past the clock edge.
  task automatic step(input logic v, input logic [7:0] d, input logic re,
                      input logic ordy, input logic r);
    in_valid = v; in_data = d; rot_en = re; out_ready = ordy; rst = r;
    if (!r && held && ordy) sb.push_back(view());
    @(posedge clk);
    #1;
    model_step(v, d, re, ordy, r);
  endtask

  task automatic chk_triple(input string name, input logic [23:0] exp);
    chk(name, {out_a, out_b, out_c}, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, (!held || out_ready));
      chk("out_valid", out_valid, held);
      chk("fill_cnt", fill_cnt, held ? 3 : words.size());
      if (held) begin
        chk("held_triple", {out_a, out_b, out_c}, view());
        chk("rot_cnt", rot_cnt, mr);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {out_a, out_b, out_c}, 24'hxxxxxx);
        end else begin
          chk("sb_output", {out_a, out_b, out_c}, sb.pop_front());
        end
      end
    end
  end

  initial begin
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // Reset mid-fill overrides all inputs.
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 1, 1, 1);
    step(1, 8'h33, 1, 1, 1);
    in_valid = 0; rst = 0; #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fill_cnt", fill_cnt, 0);
    chk("rst_rot_cnt", rot_cnt, 0);
    chk_triple("rst_slots", 24'h000000);
    chk("rst_in_ready", in_ready, 1);

    // Basic pack.
    step(1, 8'h05, 0, 0, 0);
    step(1, 8'h0A, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    chk("pack_out_valid", out_valid, 1);
    chk_triple("pack_slots", 24'h050A00);
    chk("pack_in_ready", in_ready, 0);
    chk("pack_fill_cnt", fill_cnt, 3);

    // Three rotations return to the original order.
    step(0, 8'h00, 1, 0, 0);
    chk_triple("rot1", 24'h0A0005); chk("rot1_cnt", rot_cnt, 1);
    step(0, 8'h00, 1, 0, 0);
    chk_triple("rot2", 24'h00050A); chk("rot2_cnt", rot_cnt, 2);
    step(0, 8'h00, 1, 0, 0);
    chk_triple("rot3", 24'h050A00); chk("rot3_cnt", rot_cnt, 0);

    // Drain wins over rotate.
    step(0, 8'h00, 1, 1, 0);
    chk("rvd_fill_cnt", fill_cnt, 0);
    chk("rvd_out_valid", out_valid, 0);

    // Drain-and-refill.
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0);
    chk_triple("dr_held", 24'h010203);
    step(1, 8'h44, 0, 1, 0);
    chk("dr_a", out_a, 8'h44);
    chk("dr_fill_cnt", fill_cnt, 1);
    chk("dr_out_valid", out_valid, 0);
    step(1, 8'h55, 0, 0, 0);
    step(1, 8'h66, 0, 0, 0);
    chk_triple("dr_refill", 24'h445566);

    // Backpressure: 0x77 waits until out_ready rises.
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h77, 0, 0, 0);
      chk("bp_in_ready", in_ready, 0);
      chk_triple("bp_stable", 24'h445566);
    end
    step(1, 8'h77, 0, 1, 0);
    chk("bp_a", out_a, 8'h77);
    chk("bp_fill_cnt", fill_cnt, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
